uart_tx_sequencer: RTL and testbench

//   Drains a run of bytes from the 32-entry capture buffer to the UART transmitter.
//   On start it reads the buffer sequentially from start_addr, wrapping modulo DEPTH.

---
 rtl/uart_tx_sequencer_if.sv | 23 ++
 rtl/uart_tx_sequencer.sv | 158 +++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sequencer_if.sv
// Buffer read port and UART TX handshake seen by the sequencer (master) and by
// the buffer/UART side (slave).
interface uart_tx_sequencer_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
);
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output mem_re, mem_raddr, tx_data, tx_valid,
        input  mem_rdata, tx_ready
    );

    modport slave (
        input  mem_re, mem_raddr, tx_data, tx_valid,
        output mem_rdata, tx_ready
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Drains a run of bytes from the capture buffer to the UART transmitter.
// Optional early-stop input enabled by defining UART_SEQ_ABORT_EN.
module uart_tx_sequencer #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
`ifdef UART_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sent_cnt,
    uart_tx_sequencer_if.master bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                re_q, re_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [DATA_W-1:0]   txd_q, txd_d;
    logic                txv_q, txv_d;
    logic                last_c;
`ifdef UART_SEQ_ABORT_EN
    logic                abort_q, abort_d;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            re_q    <= 1'b0;
            raddr_q <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
`ifdef UART_SEQ_ABORT_EN
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            re_q    <= re_d;
            raddr_q <= raddr_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
`ifdef UART_SEQ_ABORT_EN
            abort_q <= abort_d;
`endif
        end
    end

    // Next state; registered outputs are computed from the next state so they
    // line up with the state they describe.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        re_d    = 1'b0;
        raddr_d = raddr_q;
        txd_d   = txd_q;
        txv_d   = txv_q;
        last_c  = 1'b0;
`ifdef UART_SEQ_ABORT_EN
        abort_d = abort_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef UART_SEQ_ABORT_EN
                abort_d = 1'b0;
`endif
                if (start) begin
                    addr_d = start_addr;
                    rem_d  = (length > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : length;
                    cnt_d  = '0;
                    if (length == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        re_d    = 1'b1;
                        raddr_d = start_addr;
                    end
                end
            end
            READ: begin
                state_d = WAIT;
`ifdef UART_SEQ_ABORT_EN
                if (abort) state_d = DONE;
`endif
            end
            WAIT: begin
                state_d = SEND;
                txd_d   = bus.mem_rdata;
                txv_d   = 1'b1;
`ifdef UART_SEQ_ABORT_EN
                if (abort) begin
                    state_d = DONE;
                    txd_d   = txd_q;
                    txv_d   = 1'b0;
                end
`endif
            end
            SEND: begin
                last_c = (rem_q == CNT_W'(1));
`ifdef UART_SEQ_ABORT_EN
                abort_d = abort_q | abort;
                last_c  = last_c | abort_q | abort;
`endif
                if (txv_q && bus.tx_ready) begin
                    txv_d  = 1'b0;
                    cnt_d  = cnt_q + CNT_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - CNT_W'(1);
                    if (last_c) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        re_d    = 1'b1;
                        raddr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign sent_cnt      = cnt_q;
    assign bus.mem_re    = re_q;
    assign bus.mem_raddr = raddr_q;
    assign bus.tx_data   = txd_q;
    assign bus.tx_valid  = txv_q;
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: expected addresses/bytes are queued at
// start and consumed as the DUT reads the buffer and hands bytes to the UART.
module tb_uart_tx_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] start_addr;
    logic [5:0] length;
    logic       busy;
    logic       done;
    logic [5:0] sent_cnt;
`ifdef UART_SEQ_ABORT_EN
    logic       abort;
`endif

    uart_tx_sequencer_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    uart_tx_sequencer #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
`ifdef UART_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .sent_cnt   (sent_cnt),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [32];
    logic [7:0] exp_data [$];
    logic [4:0] exp_addr [$];
    int n_checks = 0;
    int n_fail   = 0;
    int re_cnt   = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = '0;

    // Registered-read buffer model
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_raddr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Output monitor: reads, acceptances, done pulses and stall stability
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("stall_valid", 32'(bus.tx_valid), 32'd1);
                check("stall_data", 32'(bus.tx_data), 32'(prev_data));
            end
            if (bus.mem_re) begin
                re_cnt++;
                if (exp_addr.size() == 0) check("extra_mem_re", 32'd1, 32'd0);
                else check("mem_raddr", 32'(bus.mem_raddr), 32'(exp_addr.pop_front()));
            end
            if (bus.tx_valid && bus.tx_ready) begin
                acc_cnt++;
                if (exp_data.size() == 0) check("extra_tx", 32'd1, 32'd0);
                else check("tx_data", 32'(bus.tx_data), 32'(exp_data.pop_front()));
            end
            if (done) done_cnt++;
            prev_valid = bus.tx_valid;
            prev_ready = bus.tx_ready;
            prev_data  = bus.tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [4:0] addr, input logic [5:0] len, input int n_exp);
        for (int i = 0; i < n_exp; i++) begin
            exp_addr.push_back(5'(addr + 5'(i)));
            exp_data.push_back(mem[5'(addr + 5'(i))]);
        end
        start      = 1'b1;
        start_addr = addr;
        length     = len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 400 && !done; i++) tick();
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic finish_run(input string tag, input int n_exp, input int done_base);
        wait_done(tag);
        tick();
        tick();
        check({tag, "_sent_cnt"}, 32'(sent_cnt), 32'(n_exp));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
        check({tag, "_data_left"}, 32'(exp_data.size()), 32'd0);
        check({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_sent_cnt"}, 32'(sent_cnt), 32'd0);
        check({tag, "_mem_re"}, 32'(bus.mem_re), 32'd0);
        check({tag, "_mem_raddr"}, 32'(bus.mem_raddr), 32'd0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    endtask

    initial begin
        int db, rb, ab;
        rst          = 1'b1;
        start        = 1'b0;
        start_addr   = '0;
        length       = '0;
        bus.tx_ready = 1'b1;
`ifdef UART_SEQ_ABORT_EN
        abort        = 1'b0;
`endif
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h41;
        mem[1] = 8'h42;
        mem[2] = 8'h43;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Three bytes from 0 with first-valid latency
        db = done_cnt;
        start_run(5'd0, 6'd3, 3);
        check("lat_n0", 32'(bus.tx_valid), 32'd0);
        check("busy_run", 32'(busy), 32'd1);
        tick();
        check("lat_n1", 32'(bus.tx_valid), 32'd0);
        tick();
        check("lat_n2", 32'(bus.tx_valid), 32'd1);
        check("lat_n2_data", 32'(bus.tx_data), 32'h41);
        finish_run("run3", 3, db);

        // Address wrap 30,31,0,1
        db = done_cnt;
        start_run(5'd30, 6'd4, 4);
        finish_run("wrap", 4, db);

        // Stall during byte 2; no read of byte 3 while stalled
        db = done_cnt;
        ab = acc_cnt;
        start_run(5'd5, 6'd4, 4);
        for (int i = 0; i < 50 && !(bus.tx_valid && acc_cnt == ab + 1); i++) tick();
        check("stall_reach", 32'(bus.tx_valid && acc_cnt == ab + 1), 32'd1);
        bus.tx_ready = 1'b0;
        rb = re_cnt;
        repeat (10) tick();
        check("stall_no_re", 32'(re_cnt - rb), 32'd0);
        check("stall_still_valid", 32'(bus.tx_valid), 32'd1);
        bus.tx_ready = 1'b1;
        finish_run("stall", 4, db);

        // Empty run
        db = done_cnt;
        rb = re_cnt;
        start_run(5'd9, 6'd0, 0);
        check("len0_done", 32'(done), 32'd1);
        finish_run("len0", 0, db);
        check("len0_no_re", 32'(re_cnt - rb), 32'd0);

        // Oversized run clamps to 32 bytes
        db = done_cnt;
        start_run(5'd7, 6'd40, 32);
        finish_run("len40", 32, db);

        // Start pulses mid-run and in DONE are ignored
        db = done_cnt;
        start_run(5'd12, 6'd3, 3);
        tick();
        start = 1'b1; start_addr = 5'd20; length = 6'd5;
        tick();
        start = 1'b0;
        wait_done("busy_start");
        start = 1'b1;
        tick();
        start = 1'b0;
        rb = re_cnt;
        tick();
        tick();
        check("ignored_sent_cnt", 32'(sent_cnt), 32'd3);
        check("ignored_busy", 32'(busy), 32'd0);
        check("ignored_no_re", 32'(re_cnt - rb), 32'd0);
        check("ignored_pulses", 32'(done_cnt - db), 32'd1);
        check("ignored_left", 32'(exp_data.size()), 32'd0);

        // Reset while tx_valid is high
        bus.tx_ready = 1'b0;
        start_run(5'd10, 6'd5, 5);
        for (int i = 0; i < 20 && !bus.tx_valid; i++) tick();
        check("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
        rst = 1'b1;
        tick();
        check_idle_outputs("midrun_rst");
        rst = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        bus.tx_ready = 1'b1;
        tick();

        // Recovery run after reset
        db = done_cnt;
        start_run(5'd31, 6'd2, 2);
        finish_run("recover", 2, db);

`ifdef UART_SEQ_ABORT_EN
        // Abort in SEND of byte 3 completes that byte then stops
        db = done_cnt;
        ab = acc_cnt;
        start_run(5'd0, 6'd8, 3);
        for (int i = 0; i < 60 && !(bus.tx_valid && acc_cnt == ab + 2); i++) tick();
        check("abort_reach", 32'(bus.tx_valid && acc_cnt == ab + 2), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        rb = re_cnt;
        finish_run("abort", 3, db);
        check("abort_no_re", 32'(re_cnt - rb), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
